// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS sequencer FSM with memory wait states, bus timeout, IRQ and exception entry.
// Optional PERF_COUNT_EN adds retired/cycles performance counters.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       IRQ,
  input  logic       ker,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       LuOp,
  output logic [1:0] PCSource,
  output logic       Interrupt,
  output logic       Exception,
  output logic       BusErr,
  output logic [3:0] state
`ifdef PERF_COUNT_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] cycles
`endif
);
  typedef enum logic [3:0] {
    S_IF, S_ID, S_EX_R, S_EX_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR, S_WB_R,
    S_WB_I, S_WB_MEM, S_BR, S_JMP, S_JR, S_INT, S_EXC
  } stateT;
  stateT cur, nxt, idNext, endNext;
  logic live, shiftOp, rAlu, memWait, timeout, busAbort, unusedZero;
  logic [7:0] waitCnt;
  assign unusedZero = Zero;
  assign state = cur;
  assign shiftOp = Funct inside {6'h00, 6'h02, 6'h03};
  assign rAlu = shiftOp || (Funct inside {[6'h20:6'h27], 6'h2A});
  assign idNext = OpCode == 6'h00 ? (rAlu ? S_EX_R : (Funct inside {6'h08, 6'h09}) ? S_JR : S_EXC)
    : (OpCode inside {6'h02, 6'h03}) ? S_JMP
    : (OpCode inside {6'h01, [6'h04:6'h07]}) ? S_BR
    : (OpCode inside {[6'h08:6'h0C], 6'h0F}) ? S_EX_I
    : (OpCode inside {6'h23, 6'h2B}) ? S_MEM_ADDR : S_EXC;
  assign endNext = (IRQ && !ker) ? S_INT : S_IF;
  assign memWait = cur inside {S_IF, S_MEM_RD, S_MEM_WR};
  assign timeout = waitCnt == 8'(MEM_TIMEOUT);
  assign busAbort = memWait && timeout;
  // a timeout that was already reached wins over a late mem_ready
  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF:       nxt = timeout ? S_EXC : mem_ready ? S_ID : S_IF;
      S_ID:       nxt = idNext;
      S_EX_R:     nxt = S_WB_R;
      S_EX_I:     nxt = S_WB_I;
      S_MEM_ADDR: nxt = OpCode == 6'h2B ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   nxt = timeout ? S_EXC : mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   nxt = timeout ? S_EXC : mem_ready ? endNext : S_MEM_WR;
      S_WB_R, S_WB_I, S_WB_MEM, S_BR, S_JMP, S_JR: nxt = endNext;
      default:    nxt = S_IF;
    endcase
  end
  // live is low from reset until the first edge after release, keeping every output quiet
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      live <= 1'b0;
      cur <= S_IF;
      waitCnt <= 8'd0;
      BusErr <= 1'b0;
    end else begin
      live <= 1'b1;
      if (live) begin
        cur <= nxt;
        waitCnt <= nxt == cur ? waitCnt + 8'd1 : 8'd0;
        BusErr <= BusErr | busAbort;
      end
    end
  end
  always_comb begin
    PCWrite = 1'b0;
    PCWriteCond = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst = 2'd0;
    MemtoReg = 2'd0;
    ALUSrcA = 2'd0;
    ALUSrcB = 2'd0;
    ExtOp = 1'b0;
    LuOp = 1'b0;
    PCSource = 2'd0;
    Interrupt = 1'b0;
    Exception = 1'b0;
    if (live) begin
      case (cur)
        S_IF: begin
          MemRead = 1'b1;
          ALUSrcB = 2'd1;
          IRWrite = mem_ready && !timeout;
          PCWrite = mem_ready && !timeout;
        end
        S_ID: begin
          ALUSrcB = 2'd3;
          ExtOp = 1'b1;
        end
        S_EX_R: ALUSrcA = shiftOp ? 2'd2 : 2'd1;
        S_WB_R: RegWrite = 1'b1;
        S_EX_I: begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
          ExtOp = OpCode inside {[6'h08:6'h0B]};
          LuOp = OpCode == 6'h0F;
        end
        S_WB_I: begin
          RegWrite = 1'b1;
          RegDst = 2'd1;
        end
        S_MEM_ADDR: begin
          ALUSrcA = 2'd1;
          ALUSrcB = 2'd2;
          ExtOp = 1'b1;
        end
        S_MEM_RD: begin
          IorD = 1'b1;
          MemRead = 1'b1;
        end
        S_MEM_WR: begin
          IorD = 1'b1;
          MemWrite = 1'b1;
        end
        S_WB_MEM: begin
          RegWrite = 1'b1;
          RegDst = 2'd1;
          MemtoReg = 2'd1;
        end
        S_BR: begin
          ALUSrcA = 2'd1;
          PCWriteCond = 1'b1;
          PCSource = 2'd1;
        end
        S_JMP: begin
          PCWrite = 1'b1;
          PCSource = 2'd2;
          RegWrite = OpCode == 6'h03;
          RegDst = OpCode == 6'h03 ? 2'd2 : 2'd0;
          MemtoReg = OpCode == 6'h03 ? 2'd2 : 2'd0;
        end
        S_JR: begin
          PCWrite = 1'b1;
          ALUSrcA = 2'd1;
          RegWrite = Funct == 6'h09;
          MemtoReg = Funct == 6'h09 ? 2'd2 : 2'd0;
        end
        S_INT, S_EXC: begin
          RegWrite = 1'b1;
          RegDst = 2'd3;
          MemtoReg = 2'd2;
          PCWrite = 1'b1;
          PCSource = 2'd3;
          Interrupt = cur == S_INT;
          Exception = cur == S_EXC;
        end
        default: ;
      endcase
    end
  end
`ifdef PERF_COUNT_EN
  logic instEnd;
  assign instEnd = (cur inside {S_WB_R, S_WB_I, S_WB_MEM, S_BR, S_JMP, S_JR})
    || (cur == S_MEM_WR && mem_ready && !timeout);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired <= 32'd0;
      cycles <= 32'd0;
    end else begin
      cycles <= cycles + 32'd1;
      if (live && instEnd) retired <= retired + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed and randomized instruction streams checked cycle by cycle
// against a per-instruction path model of the multicycle sequencer.
module tb_multicycle_control;
  localparam int TMO = 15;
  typedef struct packed {
    logic pcw, pcwc, iord, mr, mw, irw, rw;
    logic [1:0] rd, m2r, sa, sb;
    logic ext, lu;
    logic [1:0] pcs;
    logic intr, exc;
  } ctl_t;
  logic clk = 1'b0, reset = 1'b0;
  logic [5:0] OpCode = '0, Funct = '0;
  logic IRQ = 1'b0, ker = 1'b0, Zero = 1'b0, mem_ready = 1'b0;
  logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuOp;
  logic Interrupt, Exception, BusErr;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] state;
  ctl_t obs;
  logic expBus = 1'b0;
  int vectors = 0, miss = 0;
  logic [5:0] opList [18] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                              6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] fnList [13] = '{6'h00, 6'h02, 6'h03, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                              6'h26, 6'h27, 6'h2A, 6'h08};
  multicycle_control #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .IRQ(IRQ), .ker(ker),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .LuOp(LuOp), .PCSource(PCSource),
    .Interrupt(Interrupt), .Exception(Exception), .BusErr(BusErr), .state(state)
  );
  assign obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
                MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuOp, PCSource, Interrupt, Exception};
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic ctl_t trap(input bit isInt);
    ctl_t c = '0;
    c.rw = 1'b1; c.rd = 2'd3; c.m2r = 2'd2; c.pcw = 1'b1; c.pcs = 2'd3;
    c.intr = isInt; c.exc = !isInt;
    return c;
  endfunction
  // one clock: drive inputs just after the edge, compare mid-cycle
  task automatic cyc(input logic [3:0] st, input ctl_t c, input logic rdy, input string tag);
    mem_ready = rdy;
    Zero = 1'($urandom);
    @(negedge clk);
    vectors++;
    assert ({state, obs, BusErr} === {st, c, expBus}) else begin
      miss++;
      $error("FAIL %s: state=%0d ctl=%h busErr=%b, expected state=%0d ctl=%h busErr=%b",
             tag, state, obs, BusErr, st, c, expBus);
    end
    @(posedge clk);
    #1;
  endtask
  // memory access with w wait cycles; the access survives only if ready comes before the counter hits TMO
  task automatic access(input logic [3:0] st, input ctl_t c, input int w, input string tag, output bit ok);
    for (int i = 0; i < w && i < TMO; i++) begin
      if (st == 4'd0) OpCode = 6'($urandom);
      cyc(st, c, 1'b0, tag);
    end
    ok = w < TMO;
    if (st == 4'd0 && ok) begin c.irw = 1'b1; c.pcw = 1'b1; end
    cyc(st, c, ok || w == TMO, tag);
    if (!ok) begin
      expBus = 1'b1;
      cyc(4'd14, trap(1'b0), 1'($urandom), {tag, "-timeout"});
    end
  endtask
  task automatic runInstr(input logic [5:0] op, input logic [5:0] fn, input int ifW, input int memW,
                          input logic irq, input logic k);
    ctl_t c;
    bit ok, fin;
    IRQ = irq; ker = k;
    c = '0; c.mr = 1'b1; c.sb = 2'd1;
    access(4'd0, c, ifW, "fetch", ok);
    if (!ok) return;
    OpCode = op; Funct = fn;
    c = '0; c.sb = 2'd3; c.ext = 1'b1;
    cyc(4'd1, c, 1'($urandom), "decode");
    fin = 1'b1;
    c = '0;
    if (op == 0 && (fn == 6'h00 || fn == 6'h02 || fn == 6'h03 || (fn >= 6'h20 && fn <= 6'h27) || fn == 6'h2A)) begin
      c.sa = (fn <= 6'h03) ? 2'd2 : 2'd1;
      cyc(4'd2, c, 1'($urandom), "ex-r");
      c = '0; c.rw = 1'b1;
      cyc(4'd7, c, 1'($urandom), "wb-r");
    end else if (op == 0 && (fn == 6'h08 || fn == 6'h09)) begin
      c.pcw = 1'b1; c.sa = 2'd1; c.rw = fn == 6'h09; c.m2r = (fn == 6'h09) ? 2'd2 : 2'd0;
      cyc(4'd12, c, 1'($urandom), "jr");
    end else if (op == 6'h02 || op == 6'h03) begin
      c.pcw = 1'b1; c.pcs = 2'd2;
      if (op == 6'h03) begin c.rw = 1'b1; c.rd = 2'd2; c.m2r = 2'd2; end
      cyc(4'd11, c, 1'($urandom), "jmp");
    end else if (op == 6'h01 || (op >= 6'h04 && op <= 6'h07)) begin
      c.sa = 2'd1; c.pcwc = 1'b1; c.pcs = 2'd1;
      cyc(4'd10, c, 1'($urandom), "br");
    end else if ((op >= 6'h08 && op <= 6'h0C) || op == 6'h0F) begin
      c.sa = 2'd1; c.sb = 2'd2; c.ext = op <= 6'h0B; c.lu = op == 6'h0F;
      cyc(4'd3, c, 1'($urandom), "ex-i");
      c = '0; c.rw = 1'b1; c.rd = 2'd1;
      cyc(4'd8, c, 1'($urandom), "wb-i");
    end else if (op == 6'h23 || op == 6'h2B) begin
      c.sa = 2'd1; c.sb = 2'd2; c.ext = 1'b1;
      cyc(4'd4, c, 1'($urandom), "mem-addr");
      c = '0; c.iord = 1'b1;
      if (op == 6'h23) begin
        c.mr = 1'b1;
        access(4'd5, c, memW, "lw", ok);
        if (ok) begin
          c = '0; c.rw = 1'b1; c.rd = 2'd1; c.m2r = 2'd1;
          cyc(4'd9, c, 1'($urandom), "wb-mem");
        end
      end else begin
        c.mw = 1'b1;
        access(4'd6, c, memW, "sw", ok);
      end
      fin = ok;
    end else begin
      cyc(4'd14, trap(1'b0), 1'($urandom), "undef");
      fin = 1'b0;
    end
    if (fin && irq && !k) cyc(4'd13, trap(1'b1), 1'($urandom), "int");
  endtask
  initial begin
    ctl_t c;
    logic [5:0] op, fn;
    @(posedge clk);
    #1;
    cyc(4'd0, '0, 1'b1, "in-reset");
    reset = 1'b1;
    cyc(4'd0, '0, 1'b0, "release");
    runInstr(6'h00, 6'h20, 0, 0, 1'b0, 1'b0);
    runInstr(6'h23, 6'h15, 1, 3, 1'b0, 1'b0);
    runInstr(6'h04, 6'h00, 0, 0, 1'b0, 1'b0);
    runInstr(6'h08, 6'h00, 0, 0, 1'b1, 1'b0);
    runInstr(6'h08, 6'h00, 0, 0, 1'b1, 1'b1);
    runInstr(6'h0F, 6'h00, 0, 0, 1'b0, 1'b0);
    runInstr(6'h0C, 6'h00, 2, 0, 1'b0, 1'b0);
    runInstr(6'h03, 6'h00, 0, 0, 1'b0, 1'b0);
    runInstr(6'h00, 6'h09, 0, 0, 1'b0, 1'b0);
    runInstr(6'h00, 6'h02, 0, 0, 1'b0, 1'b0);
    runInstr(6'h2B, 6'h00, 0, 2, 1'b1, 1'b0);
    runInstr(6'h3F, 6'h00, 0, 0, 1'b1, 1'b0);
    runInstr(6'h00, 6'h01, 0, 0, 1'b0, 1'b0);
    runInstr(6'h00, 6'h20, TMO - 1, 0, 1'b0, 1'b0);
    runInstr(6'h00, 6'h20, TMO + 1, 0, 1'b0, 1'b0);
    runInstr(6'h00, 6'h20, TMO, 0, 1'b0, 1'b0);
    runInstr(6'h23, 6'h00, 0, TMO, 1'b0, 1'b0);
    runInstr(6'h23, 6'h00, 0, TMO - 1, 1'b1, 1'b0);
    IRQ = 1'b0; ker = 1'b0;
    c = '0; c.mr = 1'b1; c.sb = 2'd1; c.irw = 1'b1; c.pcw = 1'b1;
    cyc(4'd0, c, 1'b1, "sw-fetch");
    OpCode = 6'h2B;
    c = '0; c.sb = 2'd3; c.ext = 1'b1;
    cyc(4'd1, c, 1'b0, "sw-decode");
    c = '0; c.sa = 2'd1; c.sb = 2'd2; c.ext = 1'b1;
    cyc(4'd4, c, 1'b0, "sw-addr");
    c = '0; c.iord = 1'b1; c.mw = 1'b1;
    cyc(4'd6, c, 1'b0, "sw-wait");
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    assert ({MemWrite, state} === {1'b0, 4'd0}) else begin
      miss++;
      $error("FAIL async-reset: MemWrite=%b state=%0d, expected MemWrite=0 state=0", MemWrite, state);
    end
    expBus = 1'b0;
    @(posedge clk);
    #1;
    cyc(4'd0, '0, 1'b1, "held-reset");
    reset = 1'b1;
    cyc(4'd0, '0, 1'b0, "release2");
    runInstr(6'h00, 6'h24, 0, 0, 1'b0, 1'b0);
    for (int n = 0; n < 250; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : opList[$urandom_range(0, 17)];
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) :
           ($urandom_range(0, 6) == 0) ? 6'h09 : fnList[$urandom_range(0, 12)];
      runInstr(op, fn,
               ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 1) : $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0) ? $urandom_range(TMO - 2, TMO + 1) : $urandom_range(0, 3),
               1'($urandom), 1'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
